// File: rtl/shift_port_arbiter.sv
// Round-robin arbiter sharing one combinational barrel shifter between an EX-stage
// port (0) and a mul/div helper port (1), with a single registered response slot.
module shift_port_arbiter #(
   parameter logic RR_INIT = 1'b1,
   parameter int   CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [4:0]       req0_shamt,
   input  logic [31:0]      req0_data,
   input  logic [1:0]       req0_fun,
   input  logic [4:0]       req1_shamt,
   input  logic [31:0]      req1_data,
   input  logic [1:0]       req1_fun,
   output logic [4:0]       sh_A,
   output logic [31:0]      sh_B,
   output logic [1:0]       sh_ALUFun,
   input  logic [31:0]      sh_result,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1,
   output logic             dbg_full
);

   // Handshake: a request moves on a rising edge where req_valid[i] & req_ready[i];
   // a response moves on a rising edge where rsp_valid[i] & rsp_ready[i].
   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_e;

   state_e           state_q;
   logic             rsp_id_q;
   logic             last_q;
   logic [31:0]      rsp_data_q;
   logic [1:0]       rsp_valid_q;
   logic [CNT_W-1:0] cnt0_q;
   logic [CNT_W-1:0] cnt1_q;
   logic [CNT_W-1:0] cnt0_d;
   logic [CNT_W-1:0] cnt1_d;

   logic             accept;
   logic             can_issue;
   logic [1:0]       grant;
   logic             gnt_id;

   assign accept    = (state_q == S_FULL) && rsp_ready[rsp_id_q];
   // Draining the slot and refilling it in the same cycle gives 1 op/clk.
   assign can_issue = rst_n && ((state_q == S_EMPTY) || accept);

   always_comb begin
      grant = 2'b00;
      if (can_issue) begin
         case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign gnt_id = grant[1];

   always_comb begin
      sh_A      = 5'd0;
      sh_B      = 32'd0;
      sh_ALUFun = 2'b00;
      if (grant[0]) begin
         sh_A      = req0_shamt;
         sh_B      = req0_data;
         sh_ALUFun = req0_fun;
      end else if (grant[1]) begin
         sh_A      = req1_shamt;
         sh_B      = req1_data;
         sh_ALUFun = req1_fun;
      end
   end

   assign cnt0_d = (&cnt0_q) ? cnt0_q : cnt0_q + CNT_W'(1);
   assign cnt1_d = (&cnt1_q) ? cnt1_q : cnt1_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_EMPTY;
         rsp_id_q    <= 1'b0;
         last_q      <= RR_INIT;
         rsp_data_q  <= 32'd0;
         rsp_valid_q <= 2'b00;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (|grant) begin
                  state_q     <= S_FULL;
                  rsp_data_q  <= sh_result;
                  rsp_id_q    <= gnt_id;
                  last_q      <= gnt_id;
                  rsp_valid_q <= grant;
               end
            end
            S_FULL: begin
               if (|grant) begin
                  rsp_data_q  <= sh_result;
                  rsp_id_q    <= gnt_id;
                  last_q      <= gnt_id;
                  rsp_valid_q <= grant;
               end else if (accept) begin
                  state_q     <= S_EMPTY;
                  rsp_valid_q <= 2'b00;
               end
            end
            default: begin
               state_q     <= S_EMPTY;
               rsp_valid_q <= 2'b00;
            end
         endcase
         if (grant[0]) cnt0_q <= cnt0_d;
         if (grant[1]) cnt1_q <= cnt1_d;
      end
   end

   assign req_ready  = grant;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
   assign dbg_full   = (state_q == S_FULL);

`ifndef SYNTHESIS
   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
   a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));
   a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (req_ready & ~req_valid) == 2'b00);
   a_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
      ((state_q == S_FULL) && !accept) |-> (req_ready == 2'b00));
`endif

endmodule

// File: tb/tb_shift_port_arbiter.sv
// Randomised bench for shift_port_arbiter: behavioural shifter, transaction-level
// reference model and a response queue, plus the directed corner cases.
module tb_shift_port_arbiter;

   localparam int TB_CNT_W = 2;
   localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

   logic                clk;
   logic                rst_n;
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [4:0]          req0_shamt, req1_shamt;
   logic [31:0]         req0_data, req1_data;
   logic [1:0]          req0_fun, req1_fun;
   logic [4:0]          sh_A;
   logic [31:0]         sh_B;
   logic [1:0]          sh_ALUFun;
   logic [31:0]         sh_result;
   logic [1:0]          rsp_valid;
   logic [1:0]          rsp_ready;
   logic [31:0]         rsp_data;
   logic [TB_CNT_W-1:0] grant_cnt0, grant_cnt1;
   logic                dbg_full;
   logic                sh_force;

   int tests_run;
   int tests_failed;

   // reference model state
   bit          m_full;
   bit          m_id;
   bit          m_last;
   logic [31:0] m_data;
   int          m_cnt0, m_cnt1;
   logic [31:0] exp_q[$];

   shift_port_arbiter #(.RR_INIT(1'b1), .CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_shamt(req0_shamt), .req0_data(req0_data), .req0_fun(req0_fun),
      .req1_shamt(req1_shamt), .req1_data(req1_data), .req1_fun(req1_fun),
      .sh_A(sh_A), .sh_B(sh_B), .sh_ALUFun(sh_ALUFun), .sh_result(sh_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .dbg_full(dbg_full)
   );

   function automatic logic [31:0] do_shift(input logic [4:0] a, input logic [31:0] b,
                                            input logic [1:0] f);
      logic [31:0] r;
      case (f)
         2'b01:   r = b >> a;
         2'b11:   r = $signed(b) >>> a;
         default: r = b << a;
      endcase
      return r;
   endfunction

   // external shifter; sh_force stalls it at all-ones to prove the capture cycle
   assign sh_result = sh_force ? 32'hFFFF_FFFF : do_shift(sh_A, sh_B, sh_ALUFun);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_full = 1'b0;
      m_id   = 1'b0;
      m_last = 1'b1;
      m_data = 32'd0;
      m_cnt0 = 0;
      m_cnt1 = 0;
      exp_q.delete();
   endtask

   // called at a falling edge; reset asserts there, away from the active edge
   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      #1;
      model_reset();
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_cnt0", grant_cnt0, 0);
      check("rst_cnt1", grant_cnt1, 0);
      @(posedge clk);
      #1;
      check("rst_hold_ready", req_ready, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // one clock: drive, check combinational grant, clock, check registered state
   task automatic step(input logic [1:0] v, input logic [1:0] rr);
      bit          can;
      bit          g;
      logic [1:0]  g_vec;
      logic [4:0]  e_a;
      logic [31:0] e_b;
      logic [1:0]  e_f;
      logic [31:0] res;
      req_valid = v;
      rsp_ready = rr;
      #1;
      can   = !m_full || rr[m_id];
      g_vec = 2'b00;
      if (can) begin
         if (v == 2'b01)      g_vec = 2'b01;
         else if (v == 2'b10) g_vec = 2'b10;
         else if (v == 2'b11) g_vec = m_last ? 2'b01 : 2'b10;
      end
      e_a = 5'd0; e_b = 32'd0; e_f = 2'b00;
      if (g_vec[0]) begin
         e_a = req0_shamt; e_b = req0_data; e_f = req0_fun;
      end else if (g_vec[1]) begin
         e_a = req1_shamt; e_b = req1_data; e_f = req1_fun;
      end
      check("req_ready", req_ready, g_vec);
      check("sh_A", sh_A, e_a);
      check("sh_B", sh_B, e_b);
      check("sh_ALUFun", sh_ALUFun, e_f);
      if (m_full && rr[m_id] && exp_q.size() > 0)
         check("rsp_accept_data", rsp_data, exp_q.pop_front());
      @(posedge clk);
      if (g_vec != 2'b00) begin
         g   = g_vec[1];
         res = sh_force ? 32'hFFFF_FFFF : do_shift(e_a, e_b, e_f);
         m_data = res;
         m_id   = g;
         m_last = g;
         m_full = 1'b1;
         if (!g && m_cnt0 < CNT_MAX) m_cnt0++;
         if (g && m_cnt1 < CNT_MAX)  m_cnt1++;
         exp_q.push_back(res);
      end else if (m_full && rr[m_id]) begin
         m_full = 1'b0;
      end
      #1;
      check("rsp_valid", rsp_valid, m_full ? (m_id ? 2'b10 : 2'b01) : 2'b00);
      check("rsp_data", rsp_data, m_data);
      check("dbg_full", dbg_full, m_full);
      check("grant_cnt0", grant_cnt0, m_cnt0);
      check("grant_cnt1", grant_cnt1, m_cnt1);
      @(negedge clk);
   endtask

   task automatic randomize_fields();
      req0_shamt = 5'($urandom_range(0, 31));
      req0_data  = $urandom;
      req0_fun   = 2'($urandom_range(0, 3));
      req1_shamt = 5'($urandom_range(0, 31));
      req1_data  = $urandom;
      req1_fun   = 2'($urandom_range(0, 3));
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      sh_force     = 1'b0;
      req_valid    = 2'b00;
      rsp_ready    = 2'b00;
      randomize_fields();
      model_reset();
      @(negedge clk);
      apply_reset();

      // port 0 alone
      req0_shamt = 5'd4; req0_data = 32'h0000_00F1; req0_fun = 2'b00;
      step(2'b01, 2'b11);
      check("p0_rsp_valid", rsp_valid, 2'b01);
      check("p0_rsp_data", rsp_data, 32'h0000_0F10);

      // both valid, alternating grants
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         randomize_fields();
         step(2'b11, 2'b11);
      end
      check("alt_cnt0", grant_cnt0, 2);
      check("alt_cnt1", grant_cnt1, 2);

      // backpressure on port 1
      apply_reset();
      req1_shamt = 5'd8; req1_data = 32'hF000_0000; req1_fun = 2'b01;
      step(2'b10, 2'b00);
      for (int i = 0; i < 3; i++) begin
         randomize_fields();
         step(2'b11, 2'b00);
         check("bp_hold_data", rsp_data, 32'h00F0_0000);
      end
      step(2'b01, 2'b10);
      check("bp_turnaround_valid", rsp_valid, 2'b01);

      // SRA and capture of a stalled shifter value
      apply_reset();
      req0_shamt = 5'd31; req0_data = 32'h8000_0000; req0_fun = 2'b11;
      step(2'b01, 2'b11);
      check("sra_data", rsp_data, 32'hFFFF_FFFF);
      req0_shamt = 5'd4; req0_data = 32'h0000_0001; req0_fun = 2'b00;
      sh_force = 1'b1;
      step(2'b01, 2'b11);
      sh_force = 1'b0;
      check("stall_capture", rsp_data, 32'hFFFF_FFFF);
      req0_fun = 2'b10;
      step(2'b01, 2'b11);
      check("fun10_sll", rsp_data, 32'h0000_0010);

      // reset while holding a port 1 result
      apply_reset();
      randomize_fields();
      step(2'b10, 2'b00);
      check("midfull_valid", rsp_valid, 2'b10);
      apply_reset();
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      #1;
      check("post_rst_tie", req_ready, 2'b01);
      step(2'b11, 2'b11);

      // counter saturation
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         randomize_fields();
         step(2'b01, 2'b11);
      end
      check("sat_cnt0", grant_cnt0, 2'b11);

      // randomized traffic
      apply_reset();
      for (int i = 0; i < 800; i++) begin
         randomize_fields();
         sh_force = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 199) == 0) begin
            apply_reset();
         end else begin
            step(2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11);
         end
      end
      sh_force = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
